core_div_unit: RTL and testbench



---
 rtl/core_div_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_core_div_unit.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_div_unit.sv
// ----------------------------------------------------------------------------
// core_div_unit
//
// Iterative RV32M divide/remainder unit that sits beside the EX-stage ALU.
// It accepts one DIV/DIVU/REM/REMU operation and runs a radix-2 restoring
// division, one quotient bit per cycle, over XLEN cycles. A final fix-up cycle
// applies the result signs. Divide-by-zero and signed overflow skip the
// iteration and complete in the cycle after accept.
//
// Ports
//   clk_i     in   1     clock, rising edge
//   rst_i     in   1     asynchronous active-high reset
//   start_i   in   1     EX holds a valid M-extension divide op
//   funct3_i  in   3     100 DIV, 101 DIVU, 110 REM, 111 REMU
//   rs1_i     in   XLEN  dividend (forwarded value)
//   rs2_i     in   XLEN  divisor (forwarded value)
//   rd_i      in   5     destination register
//   flush_i   in   1     branch/exception flush; aborts any operation
//   busy_o    out  1     stall request (combinational)
//   done_o    out  1     one-cycle pulse, result valid
//   result_o  out  XLEN  quotient or remainder, held until next completion
//   rd_o      out  5     destination of result_o, held with it
//
// Timing: accept in cycle 0, CALC in cycles 1..XLEN, FIX in XLEN+1, done_o in
// XLEN+2. Fast path: done_o in cycle 1. A new op may be accepted in the DONE
// cycle, so back-to-back operations have no idle bubble.
// ----------------------------------------------------------------------------
module core_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Latched operation context
    logic [CW-1:0]   count_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quot_q;
    logic [XLEN-1:0] divisor_q;
    logic            neg_q_q;
    logic            neg_r_q;
    logic            op_rem_q;
    logic [4:0]      rd_q;

    // ------------------------------------------------------------------
    // Accept-cycle decode
    // ------------------------------------------------------------------
    logic            accept;
    logic            is_signed;
    logic            rs1_neg;
    logic            rs2_neg;
    logic [XLEN-1:0] rs1_mag;
    logic [XLEN-1:0] rs2_mag;
    logic            div_by_zero;
    logic            overflow;
    logic            fast;
    logic [XLEN-1:0] fast_result;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    // funct3[2] is set for every divide op; a malformed op is not accepted,
    // so it can never leave the unit stalling the pipeline.
    assign accept    = (state_q == IDLE || state_q == DONE) && start_i
                       && funct3_i[2] && !flush_i;
    assign is_signed = ~funct3_i[0];
    assign rs1_neg   = is_signed & rs1_i[XLEN-1];
    assign rs2_neg   = is_signed & rs2_i[XLEN-1];
    // |MIN_NEG| wraps to MIN_NEG, which is the correct unsigned magnitude.
    assign rs1_mag   = rs1_neg ? -rs1_i : rs1_i;
    assign rs2_mag   = rs2_neg ? -rs2_i : rs2_i;

    assign div_by_zero = (rs2_i == '0);
    assign overflow    = is_signed && (rs1_i == MIN_NEG) && (rs2_i == '1);
    assign fast        = div_by_zero || overflow;

    always_comb begin
        // NOTE: every signal written in always_comb gets a default first so
        // no path leaves it unassigned, which would otherwise infer a latch.
        fast_result = '0;
        if (funct3_i[1]) begin
            fast_result = div_by_zero ? rs1_i : '0;
        end else begin
            fast_result = div_by_zero ? '1 : MIN_NEG;
        end
    end

    // ------------------------------------------------------------------
    // One restoring-division step: shift {rem, quot} left, trial subtract.
    // The shifted remainder can need XLEN+1 bits, so the difference is one
    // bit wider and its MSB is the borrow (negative result).
    // ------------------------------------------------------------------
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quot_next;

    assign shifted   = {rem_q, quot_q[XLEN-1]};
    assign diff      = shifted - {1'b0, divisor_q};
    assign rem_next  = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    assign quot_next = {quot_q[XLEN-2:0], ~diff[XLEN]};

    // ------------------------------------------------------------------
    // Sign fix-up of the unsigned quotient and remainder
    // ------------------------------------------------------------------
    logic [XLEN-1:0] quot_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] fix_result;

    assign quot_fix   = neg_q_q ? -quot_q : quot_q;
    assign rem_fix    = neg_r_q ? -rem_q  : rem_q;
    assign fix_result = op_rem_q ? rem_fix : quot_fix;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    state_d = fast ? DONE : CALC;
                end
            end
            CALC: begin
                if (count_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A flush wins over everything, including the FIX->DONE transition.
        if (flush_i) begin
            state_d = IDLE;
        end
    end

    // Stall whenever an op is in flight or being accepted this cycle; the
    // accept term keeps the ID/EX register from advancing past the op.
    assign busy_o = ((state_q == CALC || state_q == FIX) && !flush_i) || accept;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples pre-edge values regardless of statement order.
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: the datapath registers are reset too, so the outputs and
        // internal values are defined from reset rather than left unknown.
        if (rst_i) begin
            count_q   <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            divisor_q <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            op_rem_q  <= 1'b0;
            rd_q      <= '0;
            done_o    <= 1'b0;
            result_o  <= '0;
            rd_o      <= '0;
        end else begin
            // done_o is high exactly in the cycle the FSM sits in DONE.
            done_o <= (state_d == DONE);

            if (accept) begin
                rd_q      <= rd_i;
                op_rem_q  <= funct3_i[1];
                neg_q_q   <= rs1_neg ^ rs2_neg;
                neg_r_q   <= rs1_neg;
                divisor_q <= rs2_mag;
                rem_q     <= '0;
                quot_q    <= rs1_mag;
                count_q   <= CW'(XLEN - 1);
                if (fast) begin
                    result_o <= fast_result;
                    rd_o     <= rd_i;
                end
            end else if (state_q == CALC && !flush_i) begin
                rem_q  <= rem_next;
                quot_q <= quot_next;
                if (count_q != '0) begin
                    count_q <= count_q - CW'(1);
                end
            end else if (state_q == FIX && !flush_i) begin
                result_o <= fix_result;
                rd_o     <= rd_q;
            end
        end
    end

endmodule

// File: tb/tb_core_div_unit.sv
// ----------------------------------------------------------------------------
// tb_core_div_unit
//
// Self-checking bench for core_div_unit (XLEN = 32). A behavioural model
// tracks, per cycle, whether an operation is in flight, how many clock edges
// remain until its result appears, and the held result/rd. Results come from
// plain integer division with the RV32M special cases. A compare process
// checks done_o, result_o, rd_o and busy_o every cycle; directed operations
// additionally check hand-computed results and latencies.
// ----------------------------------------------------------------------------
module tb_core_div_unit;

    localparam int XLEN = 32;
    localparam int LAT  = XLEN + 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [2:0]      funct3 = 3'b100;
    logic [XLEN-1:0] rs1 = '0;
    logic [XLEN-1:0] rs2 = '0;
    logic [4:0]      rd_in = '0;
    logic            flush = 1'b0;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    core_div_unit #(.XLEN(XLEN)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .funct3_i (funct3),
        .rs1_i    (rs1),
        .rs2_i    (rs2),
        .rd_i     (rd_in),
        .flush_i  (flush),
        .busy_o   (busy),
        .done_o   (done),
        .result_o (result),
        .rd_o     (rd_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference arithmetic
    // ------------------------------------------------------------------
    function automatic logic is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'h0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        if (b == 32'h0) begin
            r = f3[1] ? a : 32'hFFFF_FFFF;
        end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = f3[1] ? 32'h0 : 32'h8000_0000;
        end else if (!f3[0]) begin
            if (f3[1]) r = $signed(a) % $signed(b);
            else       r = $signed(a) / $signed(b);
        end else begin
            if (f3[1]) r = a % b;
            else       r = a / b;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Cycle model: m_left counts edges until a pending result appears
    // (0 means nothing in flight, i.e. a new op may be accepted).
    // ------------------------------------------------------------------
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_res  = '0;
    logic [4:0]  m_rd   = '0;
    logic [31:0] m_pres = '0;
    logic [4:0]  m_prd  = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
            m_res  = '0;
            m_rd   = '0;
        end else begin
            m_done = 1'b0;
            if (flush) begin
                m_left = 0;
            end else if (m_left != 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_res  = m_pres;
                    m_rd   = m_prd;
                end
            end else if (start && funct3[2]) begin
                if (is_fast(funct3, rs1, rs2)) begin
                    m_done = 1'b1;
                    m_res  = ref_result(funct3, rs1, rs2);
                    m_rd   = rd_in;
                end else begin
                    m_left = LAT - 1;
                    m_pres = ref_result(funct3, rs1, rs2);
                    m_prd  = rd_in;
                end
            end
        end
    end

    // Compare process: inputs change on the falling edge, outputs are
    // sampled 1 time unit later.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (chk_en) begin
                check("done_o", 32'(done), 32'(m_done));
                check("result_o", result, m_res);
                check("rd_o", 32'(rd_out), 32'(m_rd));
                check("busy_o", 32'(busy), 32'(!flush && (m_left != 0 || (start && funct3[2]))));
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers (called right after a falling edge)
    // ------------------------------------------------------------------
    task automatic drive_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
        start  = 1'b1;
        funct3 = f3;
        rs1    = a;
        rs2    = b;
        rd_in  = d;
    endtask

    // Accept an op, optionally keep start high with changing rs1 for `hold`
    // cycles, then wait (bounded) for done_o and check result and latency.
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] d,
                          input logic [31:0] exp, input int exp_lat, input int hold);
        int lat;
        @(negedge clk);
        drive_op(f3, a, b, d);
        lat = -1;
        for (int n = 1; n <= 2 * LAT; n++) begin
            @(negedge clk);
            if (n > hold) start = 1'b0;
            else          rs1   = $urandom;
            #2;
            if (done) begin
                lat = n;
                break;
            end
        end
        start = 1'b0;
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " result"}, result, exp);
        check({name, " rd"}, 32'(rd_out), 32'(d));
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 31));
            default: return $urandom;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        bit saw_done;

        #1 rst = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        check("reset result", result, 32'h0);
        check("reset rd", 32'(rd_out), 32'h0);
        check("reset done", 32'(done), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Signed, unsigned and fast-path operations with hand-computed results
        run_op("div -7/2",      3'b100, 32'hFFFF_FFF9, 32'd2,          5'd5,  32'hFFFF_FFFD, LAT, 0);
        run_op("rem -7/2",      3'b110, 32'hFFFF_FFF9, 32'd2,          5'd6,  32'hFFFF_FFFF, LAT, 0);
        run_op("divu 100/7",    3'b101, 32'd100,       32'd7,          5'd7,  32'd14,        LAT, 0);
        run_op("remu 100/7",    3'b111, 32'd100,       32'd7,          5'd8,  32'd2,         LAT, 0);
        run_op("remu max/16",   3'b111, 32'hFFFF_FFFF, 32'h10,         5'd9,  32'hF,         LAT, 0);
        run_op("div 5/0",       3'b100, 32'd5,         32'd0,          5'd10, 32'hFFFF_FFFF, 1,   0);
        run_op("rem 5/0",       3'b110, 32'd5,         32'd0,          5'd11, 32'd5,         1,   0);
        run_op("div ovf",       3'b100, 32'h8000_0000, 32'hFFFF_FFFF,  5'd12, 32'h8000_0000, 1,   0);
        run_op("rem ovf",       3'b110, 32'h8000_0000, 32'hFFFF_FFFF,  5'd13, 32'h0,         1,   0);
        run_op("divu min/max",  3'b101, 32'h8000_0000, 32'hFFFF_FFFF,  5'd14, 32'h0,         LAT, 0);
        run_op("div -100/-7",   3'b100, 32'hFFFF_FF9C, 32'hFFFF_FFF9,  5'd15, 32'd14,        LAT, 0);
        run_op("held start",    3'b101, 32'd1000,      32'd10,         5'd16, 32'd100,       LAT, 20);

        // Back-to-back: second op accepted in the first op's DONE cycle
        @(negedge clk);
        drive_op(3'b101, 32'd9, 32'd3, 5'd1);
        for (int n = 1; n <= 2 * LAT; n++) begin
            @(negedge clk);
            if (n == LAT) drive_op(3'b111, 32'd10, 32'd4, 5'd2);
            else          start = 1'b0;
            #2;
            if (n == LAT) begin
                check("b2b first done", 32'(done), 32'h1);
                check("b2b first result", result, 32'd3);
                check("b2b accept busy", 32'(busy), 32'h1);
            end
            if (n == 2 * LAT) begin
                check("b2b second done", 32'(done), 32'h1);
                check("b2b second result", result, 32'd2);
                check("b2b second rd", 32'(rd_out), 32'd2);
            end
        end

        // Flush in CALC cycle 10: busy drops, no completion, outputs held
        @(negedge clk);
        drive_op(3'b101, 32'd50, 32'd5, 5'd9);
        saw_done = 1'b0;
        for (int n = 1; n <= 2 * LAT; n++) begin
            @(negedge clk);
            start = 1'b0;
            flush = (n == 10);
            #2;
            if (n == 10) check("flush busy", 32'(busy), 32'h0);
            if (n == 11) check("idle after flush busy", 32'(busy), 32'h0);
            if (done) saw_done = 1'b1;
        end
        flush = 1'b0;
        check("flush no done", 32'(saw_done), 32'h0);
        check("flush result held", result, 32'd2);
        check("flush rd held", 32'(rd_out), 32'd2);

        // Flush in the FIX cycle: no completion, result unchanged
        @(negedge clk);
        drive_op(3'b101, 32'd60, 32'd5, 5'd4);
        saw_done = 1'b0;
        for (int n = 1; n <= 2 * LAT; n++) begin
            @(negedge clk);
            start = 1'b0;
            flush = (n == LAT - 1);
            #2;
            if (done) saw_done = 1'b1;
        end
        flush = 1'b0;
        check("fix flush no done", 32'(saw_done), 32'h0);
        check("fix flush result held", result, 32'd2);

        // Flush together with start: not accepted
        @(negedge clk);
        drive_op(3'b100, 32'd5, 32'd0, 5'd3);
        flush = 1'b1;
        #2;
        check("flush+start busy", 32'(busy), 32'h0);
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        #2;
        check("flush+start no done", 32'(done), 32'h0);

        // Asynchronous reset pulse mid-operation at cycle 20
        @(negedge clk);
        drive_op(3'b101, 32'd77, 32'd7, 5'd3);
        saw_done = 1'b0;
        for (int n = 1; n <= 2 * LAT; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 20) begin
                rst = 1'b1;
                #2;
                check("async rst result", result, 32'h0);
                check("async rst rd", 32'(rd_out), 32'h0);
                check("async rst busy", 32'(busy), 32'h0);
            end else begin
                rst = 1'b0;
                #2;
                if (done) saw_done = 1'b1;
            end
        end
        check("rst no done", 32'(saw_done), 32'h0);

        // Randomised traffic: starts at any time (ignored while busy), rare
        // flushes, operand mix biased towards the special cases.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start  = ($urandom_range(0, 3) == 0);
            funct3 = 3'(4 + $urandom_range(0, 3));
            rs1    = pick_operand();
            rs2    = pick_operand();
            rd_in  = 5'($urandom);
            flush  = ($urandom_range(0, 63) == 0);
        end
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        repeat (LAT + 4) @(negedge clk);
        #2;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
